// File: rtl/frame_buffer_pixel_writer.sv
// frame_buffer_pixel_writer: round-robin pixel write arbiter feeding the
// single frame buffer write port through a 2-stage pipeline (grant/clip
// stage, address/write stage). Optional statistics counters are enabled
// by defining PIXEL_WRITER_STATS_EN.
module frame_buffer_pixel_writer #(
  parameter int BITS_IN_FRAME_BUFFER_COLUMN  = 10,
  parameter int BITS_IN_FRAME_BUFFER_ROW     = 9,
  parameter int FRAME_BUFFER_COLUMNS         = 640,
  parameter int FRAME_BUFFER_ROWS            = 480,
  parameter int BITS_IN_FRAME_BUFFER_ADDRESS = 19,
  parameter int COLOR_BITS                   = 1,
  parameter int NUM_REQUESTERS               = 2
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic [NUM_REQUESTERS-1:0]                          requestWrPixel,
  input  logic [NUM_REQUESTERS*BITS_IN_FRAME_BUFFER_COLUMN-1:0] reqX,
  input  logic [NUM_REQUESTERS*BITS_IN_FRAME_BUFFER_ROW-1:0]    reqY,
  input  logic [NUM_REQUESTERS*COLOR_BITS-1:0]               reqColor,
  output logic [NUM_REQUESTERS-1:0]                          grantWrPixel,
  input  logic                                               fbBusy,
  output logic [BITS_IN_FRAME_BUFFER_ADDRESS-1:0]            fbAddress,
  output logic [COLOR_BITS-1:0]                              fbWrData,
  output logic                                               fbWrEn
`ifdef PIXEL_WRITER_STATS_EN
  ,
  output logic [31:0]                                        pixelsWritten,
  output logic [15:0]                                        pixelsClipped
`endif
);

  localparam int XW  = BITS_IN_FRAME_BUFFER_COLUMN;
  localparam int YW  = BITS_IN_FRAME_BUFFER_ROW;
  localparam int AW  = BITS_IN_FRAME_BUFFER_ADDRESS;
  localparam int CB  = COLOR_BITS;
  localparam int N   = NUM_REQUESTERS;
  localparam int LGW = (N > 1) ? $clog2(N) : 1;

  // One extra bit so the bound itself is representable for the compare.
  localparam logic [XW:0]   COLS_X = (XW+1)'(FRAME_BUFFER_COLUMNS);
  localparam logic [YW:0]   ROWS_Y = (YW+1)'(FRAME_BUFFER_ROWS);
  localparam logic [AW-1:0] COLS_A = AW'(FRAME_BUFFER_COLUMNS);
  localparam logic [LGW-1:0] LAST_RST = LGW'(N - 1);

  logic [LGW-1:0] lastGrant_q;
  logic [N-1:0]   grant_d;
  logic           found_d;
  logic           anyGrant_d;
  logic [LGW-1:0] selIdx_d;
  logic [XW-1:0]  selX_d;
  logic [YW-1:0]  selY_d;
  logic [CB-1:0]  selColor_d;
  logic           selInside_d;

  logic           s1Valid_q;
  logic           s1Inside_q;
  logic [XW-1:0]  s1X_q;
  logic [YW-1:0]  s1Y_q;
  logic [CB-1:0]  s1Color_q;

  logic           s2Valid_q;
  logic [AW-1:0]  fbAddress_q;
  logic [CB-1:0]  fbWrData_q;
  logic [AW-1:0]  addr_d;

  // Round-robin pick: scan offsets 1..N after the last granted index and
  // take the first requester found; the winner's pixel is muxed out too.
  always_comb begin
    grant_d    = '0;
    found_d    = 1'b0;
    selIdx_d   = lastGrant_q;
    selX_d     = '0;
    selY_d     = '0;
    selColor_d = '0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found_d && requestWrPixel[i] && (i == ((int'(lastGrant_q) + k) % N))) begin
          found_d    = 1'b1;
          grant_d[i] = 1'b1;
          selIdx_d   = LGW'(i);
          selX_d     = reqX[i*XW +: XW];
          selY_d     = reqY[i*YW +: YW];
          selColor_d = reqColor[i*CB +: CB];
        end
      end
    end
    anyGrant_d  = found_d && !fbBusy && !reset;
    selInside_d = ({1'b0, selX_d} < COLS_X) && ({1'b0, selY_d} < ROWS_Y);
  end

  // Grant is combinational in the request cycle; busy and reset mask it.
  assign grantWrPixel = anyGrant_d ? grant_d : '0;

  // Linear address; full AW-bit product so inside pixels never truncate.
  assign addr_d = AW'(s1Y_q) * COLS_A + AW'(s1X_q);

  // Pipeline and arbitration state; everything freezes while fbBusy is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lastGrant_q <= LAST_RST;
      s1Valid_q   <= 1'b0;
      s1Inside_q  <= 1'b0;
      s1X_q       <= '0;
      s1Y_q       <= '0;
      s1Color_q   <= '0;
      s2Valid_q   <= 1'b0;
      fbAddress_q <= '0;
      fbWrData_q  <= '0;
    end else if (!fbBusy) begin
      s1Valid_q <= anyGrant_d;
      if (anyGrant_d) begin
        lastGrant_q <= selIdx_d;
        s1X_q       <= selX_d;
        s1Y_q       <= selY_d;
        s1Color_q   <= selColor_d;
        s1Inside_q  <= selInside_d;
      end
      // Clipped pixels die here; they were granted so the requester moves on.
      s2Valid_q <= s1Valid_q && s1Inside_q;
      if (s1Valid_q && s1Inside_q) begin
        fbAddress_q <= addr_d;
        fbWrData_q  <= s1Color_q;
      end
    end
  end

  assign fbAddress = fbAddress_q;
  assign fbWrData  = fbWrData_q;
  // A scan-out cycle steals the port, so the held s2 pixel waits.
  assign fbWrEn    = s2Valid_q && !fbBusy;

`ifdef PIXEL_WRITER_STATS_EN
  logic [31:0] pixelsWritten_q;
  logic [15:0] pixelsClipped_q;

  // Saturating write/clip counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixelsWritten_q <= '0;
      pixelsClipped_q <= '0;
    end else begin
      if (fbWrEn && (pixelsWritten_q != '1))
        pixelsWritten_q <= pixelsWritten_q + 32'd1;
      if (!fbBusy && s1Valid_q && !s1Inside_q && (pixelsClipped_q != '1))
        pixelsClipped_q <= pixelsClipped_q + 16'd1;
    end
  end

  assign pixelsWritten = pixelsWritten_q;
  assign pixelsClipped = pixelsClipped_q;
`endif

endmodule

// File: tb/tb_frame_buffer_pixel_writer.sv
// Scoreboard bench for frame_buffer_pixel_writer: tasks push expected writes
// at grant time, a negedge monitor pops and compares every fbWrEn cycle.
module tb_frame_buffer_pixel_writer;
  localparam int XW = 10, YW = 9, AW = 19, CB = 1, N = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [N-1:0]       requestWrPixel;
  logic [N*XW-1:0]    reqX;
  logic [N*YW-1:0]    reqY;
  logic [N*CB-1:0]    reqColor;
  logic [N-1:0]       grantWrPixel;
  logic               fbBusy;
  logic [AW-1:0]      fbAddress;
  logic [CB-1:0]      fbWrData;
  logic               fbWrEn;
`ifdef PIXEL_WRITER_STATS_EN
  logic [31:0]        pixelsWritten;
  logic [15:0]        pixelsClipped;
`endif

  frame_buffer_pixel_writer dut (
    .clk(clk), .reset(reset), .requestWrPixel(requestWrPixel),
    .reqX(reqX), .reqY(reqY), .reqColor(reqColor),
    .grantWrPixel(grantWrPixel), .fbBusy(fbBusy),
    .fbAddress(fbAddress), .fbWrData(fbWrData), .fbWrEn(fbWrEn)
`ifdef PIXEL_WRITER_STATS_EN
    , .pixelsWritten(pixelsWritten), .pixelsClipped(pixelsClipped)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [CB-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  errors = 0;
  int  checks = 0;

  function automatic wr_t mk(input int x, input int y, input int c);
    wr_t w;
    w.addr = AW'(y * 640 + x);
    w.data = CB'(c);
    return w;
  endfunction

  task automatic set_req(input int r, input int x, input int y, input int c);
    reqX[r*XW +: XW]     = XW'(x);
    reqY[r*YW +: YW]     = YW'(y);
    reqColor[r*CB +: CB] = CB'(c);
  endtask

  // Every write must match the oldest outstanding expected pixel.
  always @(negedge clk) begin
    if (!reset && fbWrEn) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0d data=%0d, no write expected", fbAddress, fbWrData);
      end else begin
        mon_e = exp_q.pop_front();
        if ({fbAddress, fbWrData} !== mon_e) begin
          errors++;
          $display("FAIL write_data got addr=%0d data=%0d expected addr=%0d data=%0d",
                   fbAddress, fbWrData, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1; requestWrPixel = '0; fbBusy = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    requestWrPixel = '0;
    while (exp_q.size() != 0 && n < 20) begin @(posedge clk); n++; end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain pending=%0d expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; fbBusy = 1'b0; requestWrPixel = 2'b11;
    set_req(0, 1, 1, 1); set_req(1, 2, 2, 1);
    @(negedge clk);
    checks++; if (grantWrPixel !== 2'b00) begin errors++; $display("FAIL reset_grant got=%b expected=00", grantWrPixel); end
    checks++; if (fbWrEn !== 1'b0) begin errors++; $display("FAIL reset_wren got=%b expected=0", fbWrEn); end
    checks++; if (fbAddress !== '0) begin errors++; $display("FAIL reset_addr got=%0d expected=0", fbAddress); end
    checks++; if (fbWrData !== '0) begin errors++; $display("FAIL reset_data got=%0d expected=0", fbWrData); end
`ifdef PIXEL_WRITER_STATS_EN
    checks++; if (pixelsWritten !== 0 || pixelsClipped !== 0) begin errors++; $display("FAIL reset_stats got=%0d/%0d expected=0/0", pixelsWritten, pixelsClipped); end
`endif
    @(posedge clk); #1;
    requestWrPixel = '0; reset = 1'b0;
  endtask

  task automatic test_single();
    int px[3] = '{5, 6, 7};
    int py[3] = '{7, 7, 8};
    int pc[3] = '{1, 0, 1};
    int pa[3] = '{4485, 4486, 5127};
    for (int c = 0; c < 6; c++) begin
      if (c < 3) begin requestWrPixel = 2'b01; set_req(0, px[c], py[c], pc[c]); end
      else requestWrPixel = 2'b00;
      @(negedge clk);
      checks++;
      if (grantWrPixel !== ((c < 3) ? 2'b01 : 2'b00)) begin
        errors++; $display("FAIL single_grant c=%0d got=%b expected=%b", c, grantWrPixel, (c < 3) ? 2'b01 : 2'b00);
      end
      if (c < 3 && grantWrPixel[0]) exp_q.push_back(mk(px[c], py[c], pc[c]));
      checks++;
      if (fbWrEn !== (c >= 2 && c <= 4)) begin
        errors++; $display("FAIL single_latency c=%0d got=%b expected=%b", c, fbWrEn, (c >= 2 && c <= 4));
      end
      if (c >= 2 && c <= 4) begin
        checks++;
        if (fbAddress !== AW'(pa[c-2])) begin errors++; $display("FAIL single_addr got=%0d expected=%0d", fbAddress, pa[c-2]); end
      end
      @(posedge clk); #1;
    end
    drain("single");
  endtask

  task automatic test_alternate();
    int n[2] = '{0, 0};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      set_req(0, n[0], 20, n[0] % 2);
      set_req(1, 100 + n[1], 21, (n[1] + 1) % 2);
      requestWrPixel = 2'b11;
      @(negedge clk);
      checks++;
      if (grantWrPixel !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL alt_grant c=%0d got=%b expected=%b", c, grantWrPixel, (c % 2 == 0) ? 2'b01 : 2'b10);
      end
      if (grantWrPixel[0]) begin exp_q.push_back(mk(n[0], 20, n[0] % 2)); n[0]++; end
      else if (grantWrPixel[1]) begin exp_q.push_back(mk(100 + n[1], 21, (n[1] + 1) % 2)); n[1]++; end
      @(posedge clk); #1;
    end
    drain("alt");
    checks++;
    if (n[0] != 4 || n[1] != 4) begin errors++; $display("FAIL alt_counts got=%0d/%0d expected=4/4", n[0], n[1]); end
  endtask

  task automatic test_busy();
    int sent = 0;
    logic busy;
    for (int c = 0; c < 12; c++) begin
      busy = (c >= 1 && c <= 3);
      fbBusy = busy;
      if (sent < 4) begin requestWrPixel = 2'b01; set_req(0, 30 + sent, 40, sent % 2); end
      else requestWrPixel = 2'b00;
      @(negedge clk);
      checks++;
      if (grantWrPixel !== ((!busy && sent < 4) ? 2'b01 : 2'b00)) begin
        errors++; $display("FAIL busy_grant c=%0d got=%b expected=%b", c, grantWrPixel, (!busy && sent < 4) ? 2'b01 : 2'b00);
      end
      if (busy) begin
        checks++;
        if (fbWrEn !== 1'b0) begin errors++; $display("FAIL busy_wren c=%0d got=%b expected=0", c, fbWrEn); end
      end
      if (grantWrPixel[0]) begin exp_q.push_back(mk(30 + sent, 40, sent % 2)); sent++; end
      @(posedge clk); #1;
    end
    fbBusy = 1'b0;
    drain("busy");
  endtask

  task automatic test_clip();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      if (c == 0) begin requestWrPixel = 2'b10; set_req(1, 640, 0, 1); end
      else if (c == 1) begin requestWrPixel = 2'b10; set_req(1, 0, 480, 1); end
      else requestWrPixel = 2'b00;
      @(negedge clk);
      checks++;
      if (grantWrPixel !== ((c < 2) ? 2'b10 : 2'b00)) begin
        errors++; $display("FAIL clip_grant c=%0d got=%b expected=%b", c, grantWrPixel, (c < 2) ? 2'b10 : 2'b00);
      end
      checks++;
      if (fbWrEn !== 1'b0) begin errors++; $display("FAIL clip_wren c=%0d got=%b expected=0", c, fbWrEn); end
      @(posedge clk); #1;
    end
`ifdef PIXEL_WRITER_STATS_EN
    checks++;
    if (pixelsClipped !== 16'd2) begin errors++; $display("FAIL clip_count got=%0d expected=2", pixelsClipped); end
`endif
  endtask

  task automatic test_reset_flush();
    for (int c = 0; c < 2; c++) begin
      requestWrPixel = 2'b01; set_req(0, 300 + c, 300, 1);
      @(negedge clk);
      checks++;
      if (grantWrPixel !== 2'b01) begin errors++; $display("FAIL flush_pre_grant c=%0d got=%b expected=01", c, grantWrPixel); end
      @(posedge clk); #1;
    end
    reset = 1'b1; requestWrPixel = 2'b11;
    set_req(0, 11, 12, 1); set_req(1, 13, 14, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (grantWrPixel !== 2'b00) begin errors++; $display("FAIL flush_grant c=%0d got=%b expected=00", c, grantWrPixel); end
      checks++;
      if (fbWrEn !== 1'b0) begin errors++; $display("FAIL flush_wren c=%0d got=%b expected=0", c, fbWrEn); end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (grantWrPixel !== 2'b01) begin errors++; $display("FAIL flush_first_grant got=%b expected=01", grantWrPixel); end
    if (grantWrPixel[0]) exp_q.push_back(mk(11, 12, 1));
    else if (grantWrPixel[1]) exp_q.push_back(mk(13, 14, 0));
    @(posedge clk); #1;
    drain("flush");
  endtask

  task automatic test_stream();
    int x, y, clipped;
    clipped = 0;
    do_reset();
    for (int i = 0; i < 100; i++) begin
      if (i % 20 == 3) begin x = 640 + i; y = 5; end
      else if (i % 20 == 13) begin x = 9; y = 480 + (i % 32); end
      else begin x = (i * 7) % 640; y = (i * 3) % 480; end
      requestWrPixel = 2'b01; set_req(0, x, y, i % 2);
      @(negedge clk);
      checks++;
      if (grantWrPixel !== 2'b01) begin errors++; $display("FAIL stream_grant i=%0d got=%b expected=01", i, grantWrPixel); end
      if (grantWrPixel[0]) begin
        if (x < 640 && y < 480) exp_q.push_back(mk(x, y, i % 2));
        else clipped++;
      end
      @(posedge clk); #1;
    end
    drain("stream");
    checks++;
    if (clipped != 10) begin errors++; $display("FAIL stream_clipped_granted got=%0d expected=10", clipped); end
`ifdef PIXEL_WRITER_STATS_EN
    checks++;
    if (pixelsWritten !== 32'd90) begin errors++; $display("FAIL stats_written got=%0d expected=90", pixelsWritten); end
    checks++;
    if (pixelsClipped !== 16'd10) begin errors++; $display("FAIL stats_clipped got=%0d expected=10", pixelsClipped); end
`endif
  endtask

  initial begin
    reset = 1'b1; fbBusy = 1'b0; requestWrPixel = '0;
    reqX = '0; reqY = '0; reqColor = '0;
    test_reset();
    test_single();
    test_alternate();
    test_busy();
    test_clip();
    test_reset_flush();
    test_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
